// File: rtl/player_hit_judge.sv
// Player collision and damage stage: bullet/player overlap detection, boom handshake
// back to the bullet generator, lives bookkeeping, invulnerability blink window and game over.
module player_hit_judge #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_SHIFT   = 3,
  parameter int PLAYER_W      = 46,
  parameter int PLAYER_H      = 40,
  parameter int BULLET_W      = 10,
  parameter int BULLET_H      = 40,
  parameter int Y_OFFSET      = 480,
  parameter int BOOM_TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic [9:0] pl_x,
  input  logic [9:0] pl_y,
  input  logic [9:0] eb_x,
  input  logic [9:0] eb_y,
  input  logic       enemybullet_exist,
  output logic       boom,
  output logic       hit_pulse,
  output logic [2:0] lives,
  output logic       player_visible,
  output logic       invulnerable,
  output logic       game_over
);

  localparam int BOOM_CNT_W = $clog2(BOOM_TIMEOUT + 1);

  localparam logic [10:0]           PW       = 11'(PLAYER_W);
  localparam logic [10:0]           PH       = 11'(PLAYER_H);
  localparam logic [10:0]           BW       = 11'(BULLET_W);
  localparam logic [10:0]           BH       = 11'(BULLET_H);
  localparam logic [10:0]           YOFS     = 11'(Y_OFFSET);
  localparam logic [9:0]            EB_Y_MAX = 10'd960;
  localparam logic [2:0]            LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]            INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [BOOM_CNT_W-1:0] BOOM_LAST = BOOM_CNT_W'(BOOM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEAD
  } state_t;

  state_t                  state, state_next;
  logic [2:0]              lives_next;
  logic [7:0]              timer, timer_next;
  logic [BLINK_SHIFT:0]    blink_cnt, blink_next;
  logic                    boom_next;
  logic [BOOM_CNT_W-1:0]   boom_cnt, boom_cnt_next;
  logic                    hit;

  // Widened to 11 bits so a box near the right/bottom edge cannot wrap around.
  logic [10:0] pl_x_w, pl_y_w, eb_x_w, eb_y_w;
  logic        overlap;

  assign pl_x_w = {1'b0, pl_x};
  assign pl_y_w = {1'b0, pl_y};
  assign eb_x_w = {1'b0, eb_x};
  assign eb_y_w = {1'b0, eb_y};

  assign overlap = (eb_x_w < pl_x_w + PW)
                && (eb_x_w + BW > pl_x_w)
                && (eb_y_w < pl_y_w + YOFS + PH)
                && (eb_y_w + BH > pl_y_w + YOFS);

  assign hit = overlap && enemybullet_exist && (eb_y <= EB_Y_MAX)
            && (state == ALIVE) && !boom;

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    lives_next = lives;
    timer_next = timer;
    blink_next = blink_cnt;
    unique case (state)
      ALIVE: begin
        if (hit) begin
          lives_next = lives - 3'd1;
          if (lives == 3'd1) begin
            state_next = DEAD;
          end else begin
            state_next = INVULN;
            timer_next = INVULN_INIT;
            blink_next = '0;
          end
        end
      end
      INVULN: begin
        if (frame_tick) begin
          if (timer == 8'd0) begin
            state_next = ALIVE;
          end else begin
            timer_next = timer - 8'd1;
            blink_next = blink_cnt + 1'b1;
          end
        end
      end
      DEAD: begin
        if (restart) begin
          state_next = ALIVE;
          lives_next = LIVES_INIT;
          timer_next = '0;
          blink_next = '0;
        end
      end
      default: state_next = ALIVE;
    endcase
  end

  // The boom handshake runs independently of the life FSM so a fatal hit still retires its bullet.
  always_comb begin
    boom_next     = boom;
    boom_cnt_next = boom_cnt;
    if (hit) begin
      boom_next     = 1'b1;
      boom_cnt_next = '0;
    end else if (boom) begin
      if (!enemybullet_exist || boom_cnt == BOOM_LAST) begin
        boom_next     = 1'b0;
        boom_cnt_next = '0;
      end else begin
        boom_cnt_next = boom_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ALIVE;
      lives     <= LIVES_INIT;
      timer     <= '0;
      blink_cnt <= '0;
      boom      <= 1'b0;
      boom_cnt  <= '0;
      hit_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      lives     <= lives_next;
      timer     <= timer_next;
      blink_cnt <= blink_next;
      boom      <= boom_next;
      boom_cnt  <= boom_cnt_next;
      hit_pulse <= hit;
    end
  end

  always_comb begin
    player_visible = 1'b1;
    unique case (state)
      ALIVE:   player_visible = 1'b1;
      INVULN:  player_visible = ~blink_cnt[BLINK_SHIFT];
      DEAD:    player_visible = 1'b0;
      default: player_visible = 1'b1;
    endcase
  end

  assign invulnerable = (state == INVULN);
  assign game_over    = (state == DEAD);

endmodule

// File: tb/tb_player_hit_judge.sv
// Self-checking bench for player_hit_judge: boundary vector table, directed multi-cycle
// sequences and randomized stimulus, all compared against a frame/lives-level reference model.
module tb_player_hit_judge;

  localparam int LIVES         = 3;
  localparam int INVULN_FRAMES = 120;
  localparam int BLINK_SHIFT   = 3;
  localparam int PLAYER_W      = 46;
  localparam int PLAYER_H      = 40;
  localparam int BULLET_W      = 10;
  localparam int BULLET_H      = 40;
  localparam int Y_OFFSET      = 480;
  localparam int BOOM_TIMEOUT  = 1023;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       restart;
  logic [9:0] pl_x, pl_y, eb_x, eb_y;
  logic       enemybullet_exist;
  logic       boom;
  logic       hit_pulse;
  logic [2:0] lives;
  logic       player_visible;
  logic       invulnerable;
  logic       game_over;

  player_hit_judge #(
    .LIVES(LIVES), .INVULN_FRAMES(INVULN_FRAMES), .BLINK_SHIFT(BLINK_SHIFT),
    .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H), .BULLET_W(BULLET_W), .BULLET_H(BULLET_H),
    .Y_OFFSET(Y_OFFSET), .BOOM_TIMEOUT(BOOM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .pl_x(pl_x), .pl_y(pl_y), .eb_x(eb_x), .eb_y(eb_y),
    .enemybullet_exist(enemybullet_exist),
    .boom(boom), .hit_pulse(hit_pulse), .lives(lives),
    .player_visible(player_visible), .invulnerable(invulnerable), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: lives count, frame ticks left until vulnerable again, frames since
  // the last hit (for blinking), and how many cycles the boom request has been visible.
  int m_lives;
  int m_inv_left;
  int m_ticks;
  int m_boom_age;
  bit m_boom;
  bit m_hit;

  function automatic bit model_overlap();
    int scr_y;
    scr_y = int'(eb_y) - Y_OFFSET;
    return (int'(eb_x) < int'(pl_x) + PLAYER_W) && (int'(eb_x) + BULLET_W > int'(pl_x))
        && (scr_y < int'(pl_y) + PLAYER_H) && (scr_y + BULLET_H > int'(pl_y));
  endfunction

  function automatic bit model_visible();
    if (m_lives == 0) return 1'b0;
    if (m_inv_left > 0) return ((m_ticks / (1 << BLINK_SHIFT)) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_lives = LIVES; m_inv_left = 0; m_ticks = 0;
    m_boom = 1'b0; m_boom_age = 0; m_hit = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".boom"},      32'(boom),           32'(m_boom));
    check({tag, ".hit_pulse"}, 32'(hit_pulse),      32'(m_hit));
    check({tag, ".lives"},     32'(lives),          32'(m_lives));
    check({tag, ".visible"},   32'(player_visible), 32'(model_visible()));
    check({tag, ".invuln"},    32'(invulnerable),   32'(m_inv_left > 0));
    check({tag, ".game_over"}, 32'(game_over),      32'(m_lives == 0));
  endtask

  // One clock: predict from the pre-edge inputs, then compare just after the edge.
  task automatic step(input string tag);
    bit alive, hit, n_boom;
    int n_lives, n_inv, n_ticks, n_age;
    alive   = (m_lives != 0) && (m_inv_left == 0);
    hit     = model_overlap() && enemybullet_exist && (eb_y <= 960) && alive && !m_boom;
    n_lives = m_lives; n_inv = m_inv_left; n_ticks = m_ticks;
    n_boom  = m_boom;  n_age = m_boom_age;
    if (hit) begin
      n_boom = 1'b1; n_age = 1;
    end else if (m_boom) begin
      if (!enemybullet_exist || m_boom_age == BOOM_TIMEOUT) begin
        n_boom = 1'b0; n_age = 0;
      end else begin
        n_age = m_boom_age + 1;
      end
    end
    if (hit) begin
      n_lives = m_lives - 1;
      if (n_lives > 0) begin
        n_inv = INVULN_FRAMES + 1; n_ticks = 0;
      end
    end else if (m_lives == 0) begin
      if (restart) begin
        n_lives = LIVES; n_inv = 0; n_ticks = 0;
      end
    end else if (m_inv_left > 0 && frame_tick) begin
      n_inv = m_inv_left - 1; n_ticks = m_ticks + 1;
    end
    @(posedge clk);
    #1;
    m_lives = n_lives; m_inv_left = n_inv; m_ticks = n_ticks;
    m_boom = n_boom; m_boom_age = n_age; m_hit = hit;
    compare_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".boom"},      32'(boom),           0);
    check({tag, ".hit_pulse"}, 32'(hit_pulse),      0);
    check({tag, ".lives"},     32'(lives),          LIVES);
    check({tag, ".visible"},   32'(player_visible), 1);
    check({tag, ".invuln"},    32'(invulnerable),   0);
    check({tag, ".game_over"}, 32'(game_over),      0);
  endtask

  // Asserts reset away from a clock edge and leaves the bench at a falling edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_pos(input int px, input int py, input int ex, input int ey);
    pl_x = 10'(px); pl_y = 10'(py); eb_x = 10'(ex); eb_y = 10'(ey);
  endtask

  typedef struct {
    int pl_x, pl_y, eb_x, eb_y;
    bit exist;
    bit exp_hit;
    string name;
  } vec_t;

  vec_t vecs[$];
  int   boom_cycles;
  int   px, py, ex, ey;

  initial begin
    rst = 1'b1; frame_tick = 1'b0; restart = 1'b0; enemybullet_exist = 1'b0;
    set_pos(300, 400, 0, 0);

    // Reset and the basic hit.
    do_reset();
    set_pos(300, 400, 310, 870);
    enemybullet_exist = 1'b1;
    step("hit1");
    check("hit1.boom_rise", 32'(boom), 1);
    check("hit1.pulse", 32'(hit_pulse), 1);
    check("hit1.lives", 32'(lives), 2);
    check("hit1.invuln", 32'(invulnerable), 1);

    // Boom held while the bullet still exists, cleared one edge after it disappears.
    for (int i = 0; i < 5; i++) begin
      step("hold");
      check("hold.boom", 32'(boom), 1);
      check("hold.no_second_pulse", 32'(hit_pulse), 0);
    end
    enemybullet_exist = 1'b0;
    step("ack");
    check("ack.boom_clear", 32'(boom), 0);

    // Boundary vectors around the overlap box and the qualification terms.
    vecs.push_back('{300, 400, 345, 870, 1'b1, 1'b1, "right_in"});
    vecs.push_back('{300, 400, 346, 870, 1'b1, 1'b0, "right_touch"});
    vecs.push_back('{300, 400, 291, 870, 1'b1, 1'b1, "left_in"});
    vecs.push_back('{300, 400, 290, 870, 1'b1, 1'b0, "left_touch"});
    vecs.push_back('{300, 400, 310, 919, 1'b1, 1'b1, "bottom_in"});
    vecs.push_back('{300, 400, 310, 920, 1'b1, 1'b0, "bottom_touch"});
    vecs.push_back('{300, 400, 310, 841, 1'b1, 1'b1, "top_in"});
    vecs.push_back('{300, 400, 310, 840, 1'b1, 1'b0, "top_touch"});
    vecs.push_back('{300, 400, 310, 870, 1'b0, 1'b0, "no_exist"});
    vecs.push_back('{300, 500, 310, 960, 1'b1, 1'b1, "ey_960"});
    vecs.push_back('{300, 500, 310, 961, 1'b1, 1'b0, "ey_961"});
    vecs.push_back('{1000, 400, 1020, 870, 1'b1, 1'b1, "x_no_wrap"});
    vecs.push_back('{0, 400, 1020, 870, 1'b1, 1'b0, "x_far"});
    foreach (vecs[i]) begin
      do_reset();
      set_pos(vecs[i].pl_x, vecs[i].pl_y, vecs[i].eb_x, vecs[i].eb_y);
      enemybullet_exist = vecs[i].exist;
      step(vecs[i].name);
      check({"vec.", vecs[i].name}, 32'(hit_pulse), 32'(vecs[i].exp_hit));
    end

    // Invulnerability window with the bullet overlapping throughout.
    do_reset();
    set_pos(300, 400, 310, 870);
    enemybullet_exist = 1'b1;
    step("inv_hit");
    enemybullet_exist = 1'b0;
    step("inv_ack");
    enemybullet_exist = 1'b1;
    for (int k = 1; k <= INVULN_FRAMES + 1; k++) begin
      frame_tick = 1'b1;
      step("inv_tick");
      frame_tick = 1'b0;
      check("inv.no_hit", 32'(hit_pulse), 0);
      if (k <= INVULN_FRAMES) begin
        check("inv.still", 32'(invulnerable), 1);
        check("inv.blink", 32'(player_visible), 32'(((k >> 3) & 1) == 0));
        step("inv_idle");
        check("inv.no_hit_idle", 32'(hit_pulse), 0);
      end else begin
        check("inv.exit", 32'(invulnerable), 0);
        check("inv.exit_visible", 32'(player_visible), 1);
      end
    end
    step("inv_rehit");
    check("inv.rehit_pulse", 32'(hit_pulse), 1);
    check("inv.rehit_lives", 32'(lives), 1);

    // Three hits to game over; restart ignored outside DEAD; frame_tick coincident with a hit.
    do_reset();
    set_pos(300, 400, 310, 870);
    enemybullet_exist = 1'b1;
    step("go_hit1");
    check("go.lives1", 32'(lives), 2);
    enemybullet_exist = 1'b0;
    step("go_ack1");
    enemybullet_exist = 1'b1;
    frame_tick = 1'b1;
    for (int k = 0; k <= INVULN_FRAMES; k++) begin
      restart = (k == 10);
      step("go_inv1");
    end
    restart = 1'b0;
    check("go.restart_ignored", 32'(lives), 2);
    step("go_hit2");
    check("go.lives2", 32'(lives), 1);
    check("go.tick_hit_invuln", 32'(invulnerable), 1);
    frame_tick = 1'b0;
    enemybullet_exist = 1'b0;
    step("go_ack2");
    frame_tick = 1'b1;
    for (int k = 0; k <= INVULN_FRAMES; k++) step("go_inv2");
    check("go.alive_again", 32'(invulnerable), 0);
    frame_tick = 1'b0;
    enemybullet_exist = 1'b1;
    step("go_hit3");
    check("go.lives0", 32'(lives), 0);
    check("go.game_over", 32'(game_over), 1);
    check("go.invisible", 32'(player_visible), 0);
    for (int i = 0; i < 3; i++) begin
      step("go_boom_hold");
      check("go.boom_held_dead", 32'(boom), 1);
    end
    enemybullet_exist = 1'b0;
    step("go_ack3");
    check("go.boom_done_dead", 32'(boom), 0);
    restart = 1'b1;
    step("go_restart");
    restart = 1'b0;
    check("go.restart_lives", 32'(lives), 3);
    check("go.restart_alive", 32'(game_over), 0);

    // Boom timeout with the bullet never acknowledging, then reset mid-invulnerability.
    do_reset();
    set_pos(300, 400, 310, 870);
    enemybullet_exist = 1'b1;
    step("to_hit");
    boom_cycles = 0;
    for (int i = 0; i < 1100; i++) begin
      if (boom) boom_cycles++;
      step("to_hold");
    end
    check("timeout.boom_cycles", 32'(boom_cycles), BOOM_TIMEOUT);
    check("timeout.still_invuln", 32'(invulnerable), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized play against the reference model.
    for (int i = 0; i < 4000; i++) begin
      px = $urandom_range(0, 977);
      py = $urandom_range(0, 480);
      ex = px + $urandom_range(0, 70) - 15;
      ey = py + Y_OFFSET + $urandom_range(0, 100) - 50;
      if (ex < 0) ex = 0;
      if (ex > 1023) ex = 1023;
      if (ey > 1023) ey = 1023;
      set_pos(px, py, ex, ey);
      enemybullet_exist = m_boom ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      restart    = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
